// File: rtl/io_pkg.sv
// rtl/io_pkg.sv - shared FSM encoding and burst default for the IO write arbiter
package io_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_GNT0 = 2'd1,
        ST_GNT1 = 2'd2
    } arb_state_t;

    localparam int IO_MAX_BURST = 4;

endpackage

// File: rtl/io_wr_arbiter.sv
// rtl/io_wr_arbiter.sv - two-requester write arbiter with locked bursts toward a display peripheral
module io_wr_arbiter
    import io_pkg::*;
#(
    parameter int ADDR_W    = 8,
    parameter int DATA_W    = 8,
    parameter int MAX_BURST = IO_MAX_BURST
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              valid0,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [DATA_W-1:0] data0,
    input  logic              lock0,
    input  logic              valid1,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] data1,
    input  logic              lock1,
    output logic              ready0,
    output logic              ready1,
    output logic              we,
    output logic [ADDR_W-1:0] addr,
    output logic [DATA_W-1:0] out,
    output logic              busy
);

    localparam int CNT_W = $clog2(MAX_BURST);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_BURST - 1);

    arb_state_t       state;
    logic [CNT_W-1:0] beat_cnt;
    logic             last_grant;

    // Handshake outputs come from the state register only, never from inputs.
    assign ready0 = (state == ST_GNT0);
    assign ready1 = (state == ST_GNT1);
    assign busy   = (state != ST_IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            beat_cnt   <= '0;
            last_grant <= 1'b1;
            we         <= 1'b0;
            addr       <= '0;
            out        <= '0;
        end else begin
            we <= 1'b0;
            case (state)
                ST_IDLE: begin
                    // On a tie the requester that did not hold the last grant wins.
                    if (valid0 && (!valid1 || last_grant)) begin
                        state <= ST_GNT0;
                    end else if (valid1) begin
                        state <= ST_GNT1;
                    end
                end
                ST_GNT0: begin
                    if (valid0) begin
                        we   <= 1'b1;
                        addr <= addr0;
                        out  <= data0;
                    end
                    if (valid0 && lock0 && (beat_cnt != CNT_LAST)) begin
                        beat_cnt <= beat_cnt + 1'b1;
                    end else begin
                        state      <= ST_IDLE;
                        last_grant <= 1'b0;
                        beat_cnt   <= '0;
                    end
                end
                ST_GNT1: begin
                    if (valid1) begin
                        we   <= 1'b1;
                        addr <= addr1;
                        out  <= data1;
                    end
                    if (valid1 && lock1 && (beat_cnt != CNT_LAST)) begin
                        beat_cnt <= beat_cnt + 1'b1;
                    end else begin
                        state      <= ST_IDLE;
                        last_grant <= 1'b1;
                        beat_cnt   <= '0;
                    end
                end
                default: begin
                    state    <= ST_IDLE;
                    beat_cnt <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_io_wr_arbiter.sv
// tb/tb_io_wr_arbiter.sv - directed self-checking bench for io_wr_arbiter
module tb_io_wr_arbiter;

    logic       clk = 1'b0;
    logic       rst;
    logic       valid0, valid1, lock0, lock1;
    logic [7:0] addr0, addr1, data0, data1;
    logic       ready0, ready1, we, busy;
    logic [7:0] addr, out;

    int n_cmp = 0;
    int n_err = 0;

    io_wr_arbiter #(.ADDR_W(8), .DATA_W(8), .MAX_BURST(4)) dut (
        .clk(clk), .rst(rst),
        .valid0(valid0), .addr0(addr0), .data0(data0), .lock0(lock0),
        .valid1(valid1), .addr1(addr1), .data1(data1), .lock1(lock1),
        .ready0(ready0), .ready1(ready1),
        .we(we), .addr(addr), .out(out), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        valid0 = 1'b0; valid1 = 1'b0; lock0 = 1'b0; lock1 = 1'b0;
        addr0 = 8'h00; addr1 = 8'h00; data0 = 8'h00; data1 = 8'h00;
        tick();
        tick();
        rst = 1'b0;
    endtask

    // Locked burst rows: addr1 driven, lock1 driven, expected we/addr/ready1/busy
    typedef struct {
        logic [7:0] a1;
        logic       lk;
        logic       e_we;
        logic [7:0] e_addr;
        logic       e_rdy1;
        logic       e_busy;
    } burst_row_t;

    burst_row_t burst_tbl[8];

    // Alternating grants: expected ready0, ready1, we, addr
    logic [3:0] alt_flags[6];
    logic [7:0] alt_addr[6];

    initial begin
        burst_tbl[0] = '{8'hFC, 1'b1, 1'b0, 8'h00, 1'b1, 1'b1};
        burst_tbl[1] = '{8'hFC, 1'b1, 1'b1, 8'hFC, 1'b1, 1'b1};
        burst_tbl[2] = '{8'hFD, 1'b1, 1'b1, 8'hFD, 1'b1, 1'b1};
        burst_tbl[3] = '{8'hFE, 1'b1, 1'b1, 8'hFE, 1'b1, 1'b1};
        burst_tbl[4] = '{8'hFF, 1'b1, 1'b1, 8'hFF, 1'b0, 1'b0};
        burst_tbl[5] = '{8'hFC, 1'b1, 1'b0, 8'hFF, 1'b1, 1'b1};
        burst_tbl[6] = '{8'hFC, 1'b1, 1'b1, 8'hFC, 1'b1, 1'b1};
        burst_tbl[7] = '{8'hFD, 1'b0, 1'b1, 8'hFD, 1'b0, 1'b0};

        alt_flags[0] = 4'b1000; alt_addr[0] = 8'h00;
        alt_flags[1] = 4'b0010; alt_addr[1] = 8'h10;
        alt_flags[2] = 4'b0100; alt_addr[2] = 8'h10;
        alt_flags[3] = 4'b0010; alt_addr[3] = 8'h20;
        alt_flags[4] = 4'b1000; alt_addr[4] = 8'h20;
        alt_flags[5] = 4'b0010; alt_addr[5] = 8'h10;

        // Reset state and single unlocked write
        do_reset();
        check("rst_we", we, 1'b0);
        check("rst_addr", addr, 8'h00);
        check("rst_out", out, 8'h00);
        check("rst_busy", busy, 1'b0);
        check("rst_ready", {ready0, ready1}, 2'b00);

        valid0 = 1'b1; addr0 = 8'hFC; data0 = 8'h5A;
        tick();
        check("single_ready0", ready0, 1'b1);
        check("single_we_early", we, 1'b0);
        tick();
        check("single_we", we, 1'b1);
        check("single_addr", addr, 8'hFC);
        check("single_out", out, 8'h5A);
        check("single_ready0_off", ready0, 1'b0);
        valid0 = 1'b0;
        tick();
        check("single_we_pulse", we, 1'b0);
        check("single_addr_hold", addr, 8'hFC);

        // Constant contention alternates grants
        do_reset();
        valid0 = 1'b1; addr0 = 8'h10; data0 = 8'hA0;
        valid1 = 1'b1; addr1 = 8'h20; data1 = 8'hB0;
        for (int i = 0; i < 6; i++) begin
            tick();
            check($sformatf("alt%0d_r0", i), ready0, alt_flags[i][3]);
            check($sformatf("alt%0d_r1", i), ready1, alt_flags[i][2]);
            check($sformatf("alt%0d_we", i), we, alt_flags[i][1]);
            check($sformatf("alt%0d_addr", i), addr, alt_addr[i]);
        end

        // Locked burst capped at four beats, then regrant
        do_reset();
        valid1 = 1'b1;
        for (int i = 0; i < 8; i++) begin
            addr1 = burst_tbl[i].a1;
            data1 = burst_tbl[i].a1 ^ 8'h33;
            lock1 = burst_tbl[i].lk;
            tick();
            check($sformatf("burst%0d_we", i), we, burst_tbl[i].e_we);
            check($sformatf("burst%0d_addr", i), addr, burst_tbl[i].e_addr);
            if (burst_tbl[i].e_we)
                check($sformatf("burst%0d_out", i), out, burst_tbl[i].e_addr ^ 8'h33);
            check($sformatf("burst%0d_rdy1", i), ready1, burst_tbl[i].e_rdy1);
            check($sformatf("burst%0d_busy", i), busy, burst_tbl[i].e_busy);
        end
        valid1 = 1'b0; lock1 = 1'b0;

        // Abandoned grant counts as requester 0's turn
        do_reset();
        valid0 = 1'b1; addr0 = 8'h44; data0 = 8'h11;
        tick();
        check("abandon_gnt0", ready0, 1'b1);
        valid0 = 1'b0;
        valid1 = 1'b1; addr1 = 8'h55; data1 = 8'h22;
        tick();
        check("abandon_we", we, 1'b0);
        check("abandon_idle", busy, 1'b0);
        valid0 = 1'b1;
        tick();
        check("abandon_gnt1", {ready0, ready1}, 2'b01);
        valid0 = 1'b0;
        tick();
        check("abandon_we1", we, 1'b1);
        check("abandon_addr1", addr, 8'h55);
        check("abandon_out1", out, 8'h22);
        valid1 = 1'b0;

        // Reset mid-burst drops the pending beat and restores tie priority
        do_reset();
        valid0 = 1'b1; addr0 = 8'h30; data0 = 8'h01;
        tick();
        tick();
        check("rb_first_we", we, 1'b1);
        lock0 = 1'b1; addr0 = 8'h31;
        tick();
        check("rb_gnt0", ready0, 1'b1);
        tick();
        check("rb_beat1_we", we, 1'b1);
        check("rb_beat1_addr", addr, 8'h31);
        addr0 = 8'h32;
        rst = 1'b1;
        tick();
        check("rb_we", we, 1'b0);
        check("rb_busy", busy, 1'b0);
        check("rb_addr", addr, 8'h00);
        rst = 1'b0;
        lock0 = 1'b0;
        valid1 = 1'b1; addr1 = 8'h40;
        tick();
        check("rb_tie", {ready0, ready1}, 2'b10);
        tick();
        check("rb_tie_addr", addr, 8'h32);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/io_wr_arbiter.md
IO_WR_ARBITER -- requirements
Module: io_wr_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 8, peripheral address width.
REQ-002 SHALL have parameter DATA_W, default 8, peripheral write-data width.
REQ-003 SHALL have parameter MAX_BURST, default 4, max locked beats per grant (power of two, >=2).
REQ-004 SHALL have port clk  input  1  single clock; all logic on rising edge.
REQ-005 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-006 SHALL have ports valid0/valid1  input  1  requester write request.
REQ-007 SHALL have ports addr0/addr1  input  ADDR_W  requester write address.
REQ-008 SHALL have ports data0/data1  input  DATA_W  requester write data.
REQ-009 SHALL have ports lock0/lock1  input  1  requester asks to keep grant for the next beat.
REQ-010 SHALL have ports ready0/ready1  output  1  beat accepted this cycle when valid and ready are both high.
REQ-011 SHALL have port we  output  1  registered write strobe to display peripheral.
REQ-012 SHALL have port addr  output  ADDR_W  registered write address.
REQ-013 SHALL have port out  output  DATA_W  registered write data.
REQ-014 SHALL have port busy  output  1  high whenever state is not IDLE.

Function
REQ-015 SHALL implement FSM states IDLE, GNT0, GNT1; ready_i high only in GNTi, decoded from state register alone (no combinational path from any input).
REQ-016 IDLE: only valid0 -> GNT0; only valid1 -> GNT1; both -> GNT of requester not equal to last_grant; neither -> stay IDLE.
REQ-017 GNTi with valid_i high: beat accepted; next cycle we=1, addr=addr_i, out=data_i (latency exactly 1 cycle).
REQ-018 GNTi beat with lock_i high and beat_cnt < MAX_BURST-1: stay GNTi, beat_cnt increments.
REQ-019 GNTi beat with lock_i low, or beat_cnt == MAX_BURST-1: go IDLE, last_grant <= i, beat_cnt <= 0.
REQ-020 GNTi with valid_i low: go IDLE without a write, last_grant <= i, beat_cnt <= 0 (abandoned grant counts as a turn).
REQ-021 we SHALL be high for exactly one cycle per accepted beat, low otherwise; addr/out hold last written values when we is low.
REQ-022 Requests from the non-granted requester SHALL be ignored until the FSM returns to IDLE; no beat is lost or duplicated.
REQ-023 Unlocked throughput SHALL be one beat per two cycles per grant; locked burst SHALL sustain one beat per cycle.
REQ-024 beat_cnt SHALL be $clog2(MAX_BURST) bits and never wrap while in GNTi (forced release at MAX_BURST-1).
REQ-025 Arbiter SHALL forward all addresses unchanged; address decode (e.g. 0xFC-0xFF) is the peripheral's job.

Reset
REQ-026 When rst is high at a clock edge: state=IDLE, beat_cnt=0, last_grant=1 (requester 0 wins the first tie), we=0, addr=0, out=0; ready0=ready1=busy=0 follow from state.
REQ-027 Reset mid-burst SHALL discard the burst; a beat accepted in the cycle before reset still issues no we after reset asserts.

Structure
REQ-028 FSM state encoding and MAX_BURST default SHALL live in a shared package io_pkg.
REQ-029 Block SHALL be a single module; no sub-module required.

Verification
REQ-030 Reset, then valid0=1 addr0=0xFC data0=0x5A lock0=0 -> ready0 next cycle, we=1 addr=0xFC out=0x5A one cycle later, single pulse.
REQ-031 valid0=valid1=1 constant, locks 0 after reset -> grants alternate 0,1,0,1; we pulses every 2 cycles.
REQ-032 valid1=1 lock1=1 for 6 beats, addr1 0xFC..0xFF then 0xFC,0xFD, MAX_BURST=4 -> 4 consecutive we cycles, IDLE, regrant, 2 more beats.
REQ-033 GNT0 reached then valid0 dropped, valid1=1 -> no we for requester 0, next grant to requester 1.
REQ-034 rst pulsed during locked burst beat 2 -> we=0, busy=0 the cycle after reset; next tie goes to requester 0.
